// File: rtl/writeback_scoreboard_pkg.sv
// Shared register-file constants and the writeback result record
// carried from the result sources to the write port.
package writeback_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_result_t;

endpackage

// File: rtl/writeback_scoreboard_wb_arbiter.sv
// Fixed-priority two-source result arbiter, purely combinational; slow path
// always wins, fast path is backpressured (ready low) while slow is valid.
module wb_arbiter
  import writeback_scoreboard_pkg::*;
(
  input  logic       fast_valid,
  input  wb_result_t fast_result,
  output logic       fast_ready,
  input  logic       slow_valid,
  input  wb_result_t slow_result,
  output logic       slow_ready,
  output logic       accept,
  output wb_result_t result
);

  // Long-latency units cannot easily stall, so they never see backpressure.
  assign slow_ready = slow_valid;
  assign fast_ready = fast_valid && !slow_valid;
  assign accept     = fast_valid || slow_valid;
  assign result     = slow_valid ? slow_result : fast_result;

endmodule

// File: rtl/writeback_scoreboard.sv
// Register-file write-port owner: arbitrates fast/slow results into a 1-cycle write stage,
// tracks pending destinations and stalls issue on RAW/WAW; fast source waits while slow is valid.
module writeback_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  output logic              issue_stall,
  input  logic              fast_valid,
  input  logic [ADDR_W-1:0] fast_rd,
  input  logic [DATA_W-1:0] fast_data,
  output logic              fast_ready,
  input  logic              slow_valid,
  input  logic [ADDR_W-1:0] slow_rd,
  input  logic [DATA_W-1:0] slow_data,
  output logic              slow_ready,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_data,
  output logic              idle,
  output logic              protocol_error
);

  import writeback_scoreboard_pkg::*;

  wb_result_t          fast_result;
  wb_result_t          slow_result;
  wb_result_t          win_result;
  logic                accept;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;
  logic                rs1_hit;
  logic                rs2_hit;
  logic                rd_hit;
  logic                dispatch;
  logic                wb_load;
  logic                unexpected;

  assign fast_result = '{rd: fast_rd, data: fast_data};
  assign slow_result = '{rd: slow_rd, data: slow_data};

  wb_arbiter u_arbiter (
    .fast_valid  (fast_valid),
    .fast_result (fast_result),
    .fast_ready  (fast_ready),
    .slow_valid  (slow_valid),
    .slow_result (slow_result),
    .slow_ready  (slow_ready),
    .accept      (accept),
    .result      (win_result)
  );

  // x0 is hardwired, so it never blocks and is never tracked.
  assign rs1_hit     = (issue_rs1 != REG_ZERO) && pending[issue_rs1];
  assign rs2_hit     = (issue_rs2 != REG_ZERO) && pending[issue_rs2];
  assign rd_hit      = (issue_rd  != REG_ZERO) && pending[issue_rd];
  assign issue_stall = issue_valid && (rs1_hit || rs2_hit || rd_hit);

  assign dispatch   = issue_valid && !issue_stall && (issue_rd != REG_ZERO);
  assign wb_load    = accept && (win_result.rd != REG_ZERO);
  assign unexpected = wb_load && !pending[win_result.rd];

  // Clear first, then set, so a same-index set would take priority.
  always_comb begin
    pending_next = pending;
    if (rf_write) begin
      pending_next[rf_address] = 1'b0;
    end
    if (dispatch) begin
      pending_next[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending        <= '0;
      rf_write       <= 1'b0;
      rf_address     <= '0;
      rf_data        <= '0;
      protocol_error <= 1'b0;
    end else begin
      pending  <= pending_next;
      rf_write <= wb_load;
      if (wb_load) begin
        rf_address <= win_result.rd;
        rf_data    <= win_result.data;
      end
      if (unexpected) begin
        protocol_error <= 1'b1;
      end
    end
  end

  assign idle = (pending == '0) && !rf_write;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Randomized plus directed bench for writeback_scoreboard with a queue-based
// write scoreboard and a behavioural register-tracking model.
module tb_writeback_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        fast_valid;
  logic [4:0]  fast_rd;
  logic [31:0] fast_data;
  logic        fast_ready;
  logic        slow_valid;
  logic [4:0]  slow_rd;
  logic [31:0] slow_data;
  logic        slow_ready;
  logic        rf_write;
  logic [4:0]  rf_address;
  logic [31:0] rf_data;
  logic        idle;
  logic        protocol_error;

  writeback_scoreboard dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_stall    (issue_stall),
    .fast_valid     (fast_valid),
    .fast_rd        (fast_rd),
    .fast_data      (fast_data),
    .fast_ready     (fast_ready),
    .slow_valid     (slow_valid),
    .slow_rd        (slow_rd),
    .slow_data      (slow_data),
    .slow_ready     (slow_ready),
    .rf_write       (rf_write),
    .rf_address     (rf_address),
    .rf_data        (rf_data),
    .idle           (idle),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;

  // Reference model: set of registers awaiting a result, the write being
  // presented to the register file this cycle, and the sticky error.
  logic [31:0] m_pend;
  logic        m_wb_vld;
  logic [4:0]  m_wb_rd;
  logic        m_err;
  wr_t         exp_q[$];
  logic [4:0]  owed[$];
  logic        last_fast_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_idle();
    return (m_pend == 32'd0) && !m_wb_vld;
  endfunction

  // Called at negedge+1 with inputs already driven; returns at next negedge+1.
  task automatic cycle();
    logic        st, acc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] np;
    #2;
    st = issue_valid && ((issue_rs1 != 0 && m_pend[issue_rs1]) ||
                         (issue_rs2 != 0 && m_pend[issue_rs2]) ||
                         (issue_rd  != 0 && m_pend[issue_rd]));
    chk("issue_stall", {31'd0, issue_stall}, {31'd0, st});
    chk("slow_ready", {31'd0, slow_ready}, {31'd0, slow_valid});
    chk("fast_ready", {31'd0, fast_ready}, {31'd0, fast_valid && !slow_valid});
    last_fast_acc = fast_valid && !slow_valid;
    if (reset) begin
      m_pend   = '0;
      m_wb_vld = 1'b0;
      m_wb_rd  = '0;
      m_err    = 1'b0;
      exp_q.delete();
      owed.delete();
    end else begin
      acc  = slow_valid || fast_valid;
      rd   = slow_valid ? slow_rd : fast_rd;
      data = slow_valid ? slow_data : fast_data;
      np = m_pend;
      if (m_wb_vld) np[m_wb_rd] = 1'b0;
      if (issue_valid && !st && issue_rd != 0) begin
        np[issue_rd] = 1'b1;
        owed.push_back(issue_rd);
      end
      if (acc && rd != 0 && !m_pend[rd]) m_err = 1'b1;
      m_wb_vld = acc && (rd != 0);
      m_wb_rd  = rd;
      if (m_wb_vld) exp_q.push_back('{rd: rd, data: data});
      m_pend = np;
    end
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic quiet();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    fast_valid = 0; fast_rd = 0; fast_data = 0;
    slow_valid = 0; slow_rd = 0; slow_data = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = 1; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  // Monitor: after every edge, compare the write port, idle and error flag.
  initial begin
    wr_t  e;
    logic exp_w;
    forever begin
      @(posedge clock);
      #1;
      exp_w = exp_q.size() != 0;
      chk("rf_write", {31'd0, rf_write}, {31'd0, exp_w});
      if (exp_w) begin
        e = exp_q.pop_front();
        if (rf_write === 1'b1) begin
          chk("rf_address", {27'd0, rf_address}, {27'd0, e.rd});
          chk("rf_data", rf_data, e.data);
        end
      end
      chk("idle", {31'd0, idle}, {31'd0, model_idle()});
      chk("protocol_error", {31'd0, protocol_error}, {31'd0, m_err});
    end
  end

  initial begin
    int idx;
    m_pend = '0; m_wb_vld = 0; m_wb_rd = 0; m_err = 0; last_fast_acc = 0;
    quiet();
    reset = 1;
    cycle();
    issue_valid = 1; issue_rd = 5'($urandom); issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom);
    fast_valid = 1; fast_rd = 5'($urandom); fast_data = $urandom;
    slow_valid = 1; slow_rd = 5'($urandom); slow_data = $urandom;
    cycle();
    reset = 0;
    quiet();
    chk("rst_rf_address", {27'd0, rf_address}, 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      issue(5'($urandom), 5'($urandom), 5'($urandom));
      cycle();
      quiet();
    end
    // Flush anything the post-reset issues dispatched.
    while (owed.size() != 0) begin
      fast_valid = 1; fast_rd = owed.pop_front(); fast_data = $urandom;
      cycle();
    end
    quiet(); cycle(); cycle();

    // RAW on x5 resolved by a fast result.
    issue(5, 0, 0); cycle();
    issue(0, 5, 0); cycle();
    fast_valid = 1; fast_rd = 5; fast_data = 32'hDEADBEEF; cycle();
    fast_valid = 0; cycle();
    chk("raw_released", {31'd0, issue_stall}, 32'd0);
    cycle();

    // WAW on x7 and x0 never stalls.
    issue(7, 0, 0); cycle();
    issue(7, 1, 2); cycle();
    issue(0, 0, 0); cycle();
    quiet(); fast_valid = 1; fast_rd = 7; fast_data = 32'h77; cycle();
    quiet(); cycle(); cycle();

    // Contention: slow wins, fast holds its result one cycle.
    issue(3, 0, 0); cycle();
    issue(4, 0, 0); cycle();
    quiet();
    fast_valid = 1; fast_rd = 3; fast_data = 32'h11;
    slow_valid = 1; slow_rd = 4; slow_data = 32'h22;
    cycle();
    slow_valid = 0; cycle();
    fast_valid = 0; cycle(); cycle();

    // Result for a register nobody is waiting on.
    slow_valid = 1; slow_rd = 9; slow_data = 32'h9999; cycle();
    slow_valid = 0; cycle(); cycle(); cycle();

    // Reset with pending registers and a write in flight.
    issue(2, 0, 0); cycle();
    issue(6, 0, 0); cycle();
    quiet(); fast_valid = 1; fast_rd = 2; fast_data = 32'h2222; cycle();
    quiet(); reset = 1; cycle();
    reset = 0;
    issue(2, 6, 2); cycle();
    quiet();
    while (owed.size() != 0) begin
      fast_valid = 1; fast_rd = owed.pop_front(); fast_data = $urandom;
      cycle();
    end
    quiet(); cycle(); cycle();

    // Randomized traffic with a legal valid/ready source model.
    owed.delete();
    for (int n = 0; n < 3000; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      if (!fast_valid && owed.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, owed.size() - 1);
        fast_rd = owed[idx]; owed.delete(idx);
        fast_data = $urandom; fast_valid = 1;
      end
      slow_valid = 0;
      if (owed.size() > 0 && $urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, owed.size() - 1);
        slow_rd = owed[idx]; owed.delete(idx);
        slow_data = $urandom; slow_valid = 1;
      end else if ($urandom_range(0, 199) == 0) begin
        slow_rd = 5'($urandom); slow_data = $urandom; slow_valid = 1;
      end
      cycle();
      if (last_fast_acc) fast_valid = 0;
    end
    quiet();
    for (int i = 0; i < 4; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
